ber_meas_ctrl: RTL and testbench

Measurement controller for the bit-error-ratio tester. It sequences word-by-word comparison of the transmitted pattern against the received pattern over a programmed window of words. Over that window it accumulates the errored-bit count, the compared-bit count and the errored-word count, then reports completion with a one-cycle pulse. It sits between the pattern generator / receiver word streams and the result readout logic.

---
 rtl/ber_pkg.sv | 21 ++
 rtl/ber_word_popcnt.sv | 22 ++
 rtl/ber_meas_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_ber_meas_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ber_pkg.sv
// Shared definitions for the bit-error-ratio measurement controller: default word width,
// FSM state encoding and the sync-loss detector constants.
package ber_pkg;

    localparam int unsigned WORD_W_DEF   = 13;
    localparam int unsigned SYNC_THR     = WORD_W_DEF / 2;
    localparam int unsigned SYNC_RUN_LEN = 4;

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StDrain,
        StDone
    } ber_state_e;

    // A word is "badly errored" when more than half of its bits differ.
    function automatic int unsigned sync_thr(input int unsigned word_w);
        return word_w / 2;
    endfunction

endpackage

// File: rtl/ber_word_popcnt.sv
// Combinational compare of two pattern words: bitwise XOR followed by a count of differing bits.
module ber_word_popcnt #(
    parameter int unsigned WORD_W = 13,
    parameter int unsigned POP_W  = $clog2(WORD_W + 1)
) (
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    output logic [POP_W-1:0]  pop_o
);

    logic [WORD_W-1:0] diff;

    assign diff = a_i ^ b_i;

    always_comb begin
        pop_o = '0;
        for (int i = 0; i < WORD_W; i++) begin
            pop_o = pop_o + POP_W'(diff[i]);
        end
    end

endmodule

// File: rtl/ber_meas_ctrl.sv
// BER measurement controller: windowed word compare with saturating error/bit counters.
// Optional consecutive-bad-word sync-loss abort is enabled by defining BER_SYNC_LOSS_EN.
module ber_meas_ctrl
    import ber_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned WIN_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WIN_W-1:0]  win_words,
    input  logic [WORD_W-1:0] tx_word,
    input  logic [WORD_W-1:0] rx_word,
    input  logic              word_vld,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              sat,
    output logic [CNT_W-1:0]  err_bits,
    output logic [CNT_W-1:0]  err_words,
    output logic [CNT_W-1:0]  tot_bits,
    output logic              sync_lost
);

    localparam int unsigned      POP_W   = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // MSB of the result flags that the counter has reached all-ones.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] acc,
                                               input logic [CNT_W-1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        if (sum >= {1'b0, CNT_MAX}) begin
            return {1'b1, CNT_MAX};
        end
        return {1'b0, sum[CNT_W-1:0]};
    endfunction

    ber_state_e        state_q, state_d;
    logic [WIN_W-1:0]  remain_q, remain_d;
    logic              s1_vld_q, s1_vld_d;
    logic [POP_W-1:0]  s1_pop_q, s1_pop_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  err_bits_q, err_bits_d;
    logic [CNT_W-1:0]  err_words_q, err_words_d;
    logic [CNT_W-1:0]  tot_bits_q, tot_bits_d;

    logic [POP_W-1:0]  pop;
    logic [CNT_W:0]    eb_sum, ew_sum, tb_sum;
    logic              start_ok, abort_kill, kill, accept, sync_trip;

    ber_word_popcnt #(
        .WORD_W (WORD_W),
        .POP_W  (POP_W)
    ) u_popcnt (
        .a_i   (tx_word),
        .b_i   (rx_word),
        .pop_o (pop)
    );

    assign eb_sum = sat_add(err_bits_q, CNT_W'(s1_pop_q));
    assign ew_sum = sat_add(err_words_q, CNT_W'(s1_pop_q != '0));
    assign tb_sum = sat_add(tot_bits_q, CNT_W'(WORD_W));

    assign start_ok   = (state_q == StIdle) && start && (win_words != '0);
    assign abort_kill = ((state_q == StMeasure) || (state_q == StDrain)) && abort;
    assign kill       = abort_kill || sync_trip;
    assign accept     = (state_q == StMeasure) && word_vld && !kill;

`ifdef BER_SYNC_LOSS_EN
    localparam int unsigned RUN_W = $clog2(SYNC_RUN_LEN + 1);
    logic [RUN_W-1:0] run_q, run_d;
    logic             sync_lost_q, sync_lost_d;
    logic             bad;

    assign bad       = s1_pop_q > POP_W'(sync_thr(WORD_W));
    // The word completing the run is still counted; everything behind it is dropped.
    assign sync_trip = s1_vld_q && !abort_kill && bad && (run_q == RUN_W'(SYNC_RUN_LEN - 1));
    assign sync_lost = sync_lost_q;
`else
    assign sync_trip = 1'b0;
    assign sync_lost = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        s1_vld_d    = accept;
        s1_pop_d    = accept ? pop : s1_pop_q;
        aborted_d   = aborted_q;
        sat_d       = sat_q;
        err_bits_d  = err_bits_q;
        err_words_d = err_words_q;
        tot_bits_d  = tot_bits_q;
`ifdef BER_SYNC_LOSS_EN
        run_d       = run_q;
        sync_lost_d = sync_lost_q;
`endif

        if (s1_vld_q && !abort_kill) begin
            err_bits_d  = eb_sum[CNT_W-1:0];
            err_words_d = ew_sum[CNT_W-1:0];
            tot_bits_d  = tb_sum[CNT_W-1:0];
            sat_d       = sat_q | eb_sum[CNT_W] | ew_sum[CNT_W] | tb_sum[CNT_W];
`ifdef BER_SYNC_LOSS_EN
            run_d       = bad ? run_q + RUN_W'(1) : '0;
            if (sync_trip) begin
                sync_lost_d = 1'b1;
            end
`endif
        end

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d     = StMeasure;
                    remain_d    = win_words;
                    err_bits_d  = '0;
                    err_words_d = '0;
                    tot_bits_d  = '0;
                    aborted_d   = 1'b0;
                    sat_d       = 1'b0;
`ifdef BER_SYNC_LOSS_EN
                    run_d       = '0;
                    sync_lost_d = 1'b0;
`endif
                end
            end
            StMeasure: begin
                if (kill) begin
                    state_d   = StIdle;
                    aborted_d = 1'b1;
                end else if (word_vld) begin
                    remain_d = remain_q - WIN_W'(1);
                    if (remain_q == WIN_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (kill) begin
                    state_d   = StIdle;
                    aborted_d = 1'b1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StMeasure) || (state_d == StDrain);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            remain_q    <= '0;
            s1_vld_q    <= 1'b0;
            s1_pop_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            sat_q       <= 1'b0;
            err_bits_q  <= '0;
            err_words_q <= '0;
            tot_bits_q  <= '0;
`ifdef BER_SYNC_LOSS_EN
            run_q       <= '0;
            sync_lost_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            s1_vld_q    <= s1_vld_d;
            s1_pop_q    <= s1_pop_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            sat_q       <= sat_d;
            err_bits_q  <= err_bits_d;
            err_words_q <= err_words_d;
            tot_bits_q  <= tot_bits_d;
`ifdef BER_SYNC_LOSS_EN
            run_q       <= run_d;
            sync_lost_q <= sync_lost_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign sat       = sat_q;
    assign err_bits  = err_bits_q;
    assign err_words = err_words_q;
    assign tot_bits  = tot_bits_q;

endmodule

// File: tb/tb_ber_meas_ctrl.sv
// Testbench for ber_meas_ctrl: directed windows plus randomized windows, all checked each cycle
// against a transaction-level model of the measurement rules.
module tb_ber_meas_ctrl;

    localparam int unsigned WORD_W = 13;
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned WIN_W  = 24;
    localparam longint      CMAX   = (longint'(1) << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              word_vld = 1'b0;
    logic [WIN_W-1:0]  win_words = '0;
    logic [WORD_W-1:0] tx_word = '0;
    logic [WORD_W-1:0] rx_word = '0;
    logic              busy, done, aborted, sat, sync_lost;
    logic [CNT_W-1:0]  err_bits, err_words, tot_bits;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ber_meas_ctrl #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W),
        .WIN_W  (WIN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .win_words (win_words),
        .tx_word   (tx_word),
        .rx_word   (rx_word),
        .word_vld  (word_vld),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .sat       (sat),
        .err_bits  (err_bits),
        .err_words (err_words),
        .tot_bits  (tot_bits),
        .sync_lost (sync_lost)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 measuring, 2 draining, 3 done; one compared word may be in flight.
    int     m_phase = 0;
    int     m_left  = 0;
    int     m_pop   = 0;
    int     m_run   = 0;
    bit     m_pv    = 1'b0;
    bit     m_abt   = 1'b0;
    bit     m_sat   = 1'b0;
    bit     m_sl    = 1'b0;
    longint m_eb    = 0;
    longint m_ew    = 0;
    longint m_tb    = 0;

    task automatic acc(inout longint c, input longint inc);
        c = c + inc;
        if (c >= CMAX) begin
            c     = CMAX;
            m_sat = 1'b1;
        end
    endtask

    task automatic model_edge();
        bit kill;
        bit trip;
        bit take;
        kill = ((m_phase == 1) || (m_phase == 2)) && (abort == 1'b1);
        trip = 1'b0;
        if (m_pv && !kill) begin
            acc(m_eb, longint'(m_pop));
            acc(m_tb, longint'(WORD_W));
            acc(m_ew, (m_pop != 0) ? 1 : 0);
`ifdef BER_SYNC_LOSS_EN
            m_run = (m_pop > int'(WORD_W / 2)) ? m_run + 1 : 0;
            if (m_run >= 4) begin
                trip = 1'b1;
                m_sl = 1'b1;
            end
`endif
        end
        take  = (m_phase == 1) && (word_vld == 1'b1) && !kill && !trip;
        m_pv  = take;
        m_pop = $countones(tx_word ^ rx_word);
        case (m_phase)
            0: if (start == 1'b1 && win_words != '0) begin
                m_phase = 1;
                m_left  = int'(win_words);
                m_eb    = 0;
                m_ew    = 0;
                m_tb    = 0;
                m_abt   = 1'b0;
                m_sat   = 1'b0;
                m_sl    = 1'b0;
                m_run   = 0;
            end
            1: if (kill || trip) begin
                m_phase = 0;
                m_abt   = 1'b1;
            end else if (take) begin
                m_left--;
                if (m_left == 0) m_phase = 2;
            end
            2: if (kill || trip) begin
                m_phase = 0;
                m_abt   = 1'b1;
            end else begin
                m_phase = 3;
            end
            default: m_phase = 0;
        endcase
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_phase = 0; m_left = 0; m_pop = 0; m_run = 0; m_pv = 1'b0;
            m_abt = 1'b0; m_sat = 1'b0; m_sl = 1'b0; m_eb = 0; m_ew = 0; m_tb = 0;
        end else begin
            model_edge();
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check("busy", busy, ((m_phase == 1) || (m_phase == 2)) ? 1 : 0);
            check("done", done, (m_phase == 3) ? 1 : 0);
            check("aborted", aborted, m_abt);
            check("sat", sat, m_sat);
            check("sync_lost", sync_lost, m_sl);
            check("err_bits", err_bits, m_eb);
            check("err_words", err_words, m_ew);
            check("tot_bits", tot_bits, m_tb);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_win(input int w);
        start     = 1'b1;
        win_words = WIN_W'(w);
        step();
        start     = 1'b0;
    endtask

    task automatic word(input logic [WORD_W-1:0] tx, input logic [WORD_W-1:0] rx, input bit vld);
        tx_word  = tx;
        rx_word  = rx;
        word_vld = vld;
        step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " aborted"}, aborted, 0);
        check({tag, " sat"}, sat, 0);
        check({tag, " sync_lost"}, sync_lost, 0);
        check({tag, " err_bits"}, err_bits, 0);
        check({tag, " err_words"}, err_words, 0);
        check({tag, " tot_bits"}, tot_bits, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2 ms");
        $fatal(1);
    end

    initial begin
        logic [WORD_W-1:0] t;
        bit pat[7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        step();

        // Clean window of five identical words.
        start_win(5);
        check("w5 busy after start", busy, 1);
        for (int i = 0; i < 5; i++) word(13'h1ABC, 13'h1ABC, 1'b1);
        word_vld = 1'b0;
        step();
        check("w5 done", done, 1);
        check("w5 err_bits", err_bits, 0);
        check("w5 err_words", err_words, 0);
        check("w5 tot_bits", tot_bits, 65);
        step();
        check("w5 done one cycle", done, 0);
        step();

        // Three words: one bit wrong, all bits wrong, clean.
        start_win(3);
        check("w3 tot cleared", tot_bits, 0);
        t = WORD_W'($urandom); word(t, t ^ 13'h0001, 1'b1);
        t = WORD_W'($urandom); word(t, t ^ 13'h1FFF, 1'b1);
        t = WORD_W'($urandom); word(t, t, 1'b1);
        word_vld = 1'b0;
        step();
        check("w3 done", done, 1);
        check("w3 err_bits", err_bits, 14);
        check("w3 err_words", err_words, 2);
        check("w3 tot_bits", tot_bits, 39);
        step();
        step();

        // Gapped word_vld.
        start_win(4);
        for (int i = 0; i < 7; i++) word(13'h0F0F, 13'h0F0F, pat[i]);
        word_vld = 1'b0;
        step();
        check("gap done", done, 1);
        check("gap tot_bits", tot_bits, 52);
        step();
        step();

        // Abort after two words; the second is still in the compare stage and is dropped.
        start_win(10);
        word(13'h0123, 13'h0123, 1'b1);
        word(13'h0456, 13'h0457, 1'b1);
        abort    = 1'b1;
        word_vld = 1'b1;
        step();
        abort    = 1'b0;
        word_vld = 1'b0;
        check("abort busy", busy, 0);
        check("abort aborted", aborted, 1);
        check("abort tot_bits", tot_bits, 13);
        check("abort err_bits", err_bits, 0);
        step();
        check("abort no done", done, 0);
        start_win(1);
        check("restart clears aborted", aborted, 0);
        word(13'h1111, 13'h1111, 1'b1);
        word_vld = 1'b0;
        step();
        check("min window done", done, 1);
        step();
        step();

        // Zero-length window is ignored, then reset mid-measurement.
        start_win(0);
        check("win0 busy", busy, 0);
        start_win(10);
        for (int i = 0; i < 3; i++) word(13'h0AAA, 13'h1555, 1'b1);
        reset = 1'b1;
        #1;
        check_zero("async reset");
        word_vld = 1'b0;
        step();
        reset = 1'b0;
        step();

        // Four badly errored words in a row.
        start_win(4);
        for (int i = 0; i < 4; i++) begin
            t = WORD_W'($urandom);
            word(t, t ^ 13'h1FFF, 1'b1);
        end
        word_vld = 1'b0;
        step();
        check("bad4 err_bits", err_bits, 52);
`ifdef BER_SYNC_LOSS_EN
        check("bad4 sync_lost", sync_lost, 1);
        check("bad4 aborted", aborted, 1);
        check("bad4 no done", done, 0);
        check("bad4 busy", busy, 0);
`else
        check("bad4 done", done, 1);
        check("bad4 sync_lost", sync_lost, 0);
        check("bad4 aborted", aborted, 0);
`endif
        step();
        step();

        // Long window saturates tot_bits at 1023.
        start_win(90);
        for (int i = 0; i < 90; i++) begin
            t = WORD_W'($urandom);
            word(t, t ^ (((i % 2) == 1) ? 13'h1FFF : 13'h0000), 1'b1);
        end
        word_vld = 1'b0;
        step();
        check("sat done", done, 1);
        check("sat tot_bits", tot_bits, 1023);
        check("sat err_bits", err_bits, 585);
        check("sat err_words", err_words, 45);
        check("sat flag", sat, 1);
        step();
        step();

        // Randomized windows with gaps, stray starts and occasional aborts.
        for (int w = 0; w < 40; w++) begin
            int cyc;
            start_win(int'($urandom_range(0, 12)));
            cyc = 0;
            while (m_phase != 0 && cyc < 300) begin
                logic [WORD_W-1:0] mask;
                case ($urandom_range(0, 3))
                    0:       mask = '0;
                    1:       mask = WORD_W'(1 << $urandom_range(0, WORD_W - 1));
                    2:       mask = WORD_W'($urandom);
                    default: mask = 13'h1FFF;
                endcase
                t         = WORD_W'($urandom);
                tx_word   = t;
                rx_word   = t ^ mask;
                word_vld  = ($urandom_range(0, 9) < 7);
                abort     = ($urandom_range(0, 59) == 0);
                start     = ($urandom_range(0, 9) == 0);
                win_words = WIN_W'($urandom_range(0, 12));
                step();
                cyc++;
            end
            start    = 1'b0;
            abort    = 1'b0;
            word_vld = 1'b0;
            check("random window ends idle", busy, 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
